// File: rtl/jtag_ahb_master.sv
// AHB-Lite single-transfer master executing JTAG read/write requests queued in a small FIFO.
// Optional feature macro: JTAG_AHB_AUTOINC_EN (adds req_incr and an auto-increment address).
module jtag_ahb_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef JTAG_AHB_AUTOINC_EN
  input  logic                  req_incr,
`endif
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  state_t state_r, state_nxt_s;

  // Only word-aligned addresses are stored; the byte-lane bits are dropped.
  logic [ADDR_WIDTH-3:0] fifo_addr_r  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata_r [FIFO_DEPTH];
  logic                  fifo_write_r [FIFO_DEPTH];
`ifdef JTAG_AHB_AUTOINC_EN
  logic                  fifo_incr_r  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] next_addr_r;
`endif
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [DATA_WIDTH-1:0] cur_wdata_r;

  logic                  push_s, pop_s, addr_accept_s, done_ok_s, done_err_s;
  logic [ADDR_WIDTH-1:0] issue_addr_s;
  logic                  addr_lsb_unused_s;

  assign addr_lsb_unused_s = ^req_addr[1:0];
  assign req_ready = (count_r != FULL_CNT);
  assign push_s    = req_valid && req_ready;
  assign pop_s     = (state_r == ST_IDLE) && (count_r != {CNT_W{1'b0}});
  assign busy      = (count_r != {CNT_W{1'b0}}) || (state_r != ST_IDLE);
  assign HSIZE     = 3'b010;

`ifdef JTAG_AHB_AUTOINC_EN
  assign issue_addr_s = fifo_incr_r[rd_ptr_r] ? next_addr_r : {fifo_addr_r[rd_ptr_r], 2'b00};
`else
  assign issue_addr_s = {fifo_addr_r[rd_ptr_r], 2'b00};
`endif

  // Request FIFO storage, pointers and occupancy count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_r[i]  <= {(ADDR_WIDTH-2){1'b0}};
        fifo_wdata_r[i] <= {DATA_WIDTH{1'b0}};
        fifo_write_r[i] <= 1'b0;
`ifdef JTAG_AHB_AUTOINC_EN
        fifo_incr_r[i]  <= 1'b0;
`endif
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r]  <= req_addr[ADDR_WIDTH-1:2];
        fifo_wdata_r[wr_ptr_r] <= req_wdata;
        fifo_write_r[wr_ptr_r] <= req_write;
`ifdef JTAG_AHB_AUTOINC_EN
        fifo_incr_r[wr_ptr_r]  <= req_incr;
`endif
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Transfer sequencing: next state and completion/accept strobes.
  always_comb begin
    state_nxt_s   = state_r;
    addr_accept_s = 1'b0;
    done_ok_s     = 1'b0;
    done_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_nxt_s = ST_ADDR;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (HREADY) begin
          addr_accept_s = 1'b1;
          state_nxt_s   = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          done_ok_s   = !HRESP;
          done_err_s  = HRESP;
          state_nxt_s = ST_IDLE;
        end else if (HRESP) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          done_err_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ERR;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // AHB address/data phase signals; write data is held locally once its FIFO slot is freed.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR       <= {ADDR_WIDTH{1'b0}};
      HTRANS      <= TRANS_IDLE;
      HWRITE      <= 1'b0;
      HWDATA      <= {DATA_WIDTH{1'b0}};
      cur_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (pop_s) begin
        HADDR       <= issue_addr_s;
        HTRANS      <= TRANS_NONSEQ;
        HWRITE      <= fifo_write_r[rd_ptr_r];
        cur_wdata_r <= fifo_wdata_r[rd_ptr_r];
      end else if (addr_accept_s) begin
        HTRANS <= TRANS_IDLE;
        if (HWRITE) HWDATA <= cur_wdata_r;
      end
    end
  end

`ifdef JTAG_AHB_AUTOINC_EN
  // Auto-increment address follows each accepted address phase, wrapping by truncation.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)           next_addr_r <= {ADDR_WIDTH{1'b0}};
    else if (addr_accept_s) next_addr_r <= HADDR + ADDR_WIDTH'(32'd4);
  end
`endif

  // Response pulse and held read data / error status.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      resp_valid <= 1'b0;
      resp_rdata <= {DATA_WIDTH{1'b0}};
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= done_ok_s || done_err_s;
      if (done_ok_s) begin
        resp_err <= 1'b0;
        if (!HWRITE) resp_rdata <= HRDATA;
      end else if (done_err_s) begin
        resp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_ahb_master.sv
// Randomised self-checking bench for jtag_ahb_master with a transaction-level reference model.
module tb_jtag_ahb_master;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = 32'h0;
  logic [DW-1:0] req_wdata = 32'h0;
`ifdef JTAG_AHB_AUTOINC_EN
  logic          req_incr = 1'b0;
`endif
  logic          HREADY = 1'b1, HRESP = 1'b0;
  logic [DW-1:0] HRDATA = 32'h0;
  logic          req_ready, resp_valid, resp_err, busy, HWRITE;
  logic [DW-1:0] resp_rdata, HWDATA;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;

  jtag_ahb_master #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef JTAG_AHB_AUTOINC_EN
    .req_incr(req_incr),
`endif
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          incr;
  } req_t;

  req_t          m_q[$];
  req_t          m_cur;
  bit            m_in_addr = 0, m_in_data = 0, m_err_seen = 0;
  logic [AW-1:0] m_next_addr = 32'h0;
  logic [AW-1:0] e_haddr = 32'h0;
  logic [1:0]    e_htrans = 2'b00;
  logic          e_hwrite = 1'b0, e_rv = 1'b0, e_err = 1'b0;
  logic [DW-1:0] e_hwdata = 32'h0, e_rdata = 32'h0;

  task automatic model_clear();
    m_q.delete();
    m_in_addr = 0; m_in_data = 0; m_err_seen = 0;
    m_next_addr = 32'h0; e_haddr = 32'h0; e_htrans = 2'b00; e_hwrite = 1'b0;
    e_hwdata = 32'h0; e_rv = 1'b0; e_rdata = 32'h0; e_err = 1'b0;
  endtask

  task automatic model_step();
    bit   do_push;
    req_t nr;
    do_push  = req_valid && (m_q.size() < DEPTH);
    nr.write = req_write; nr.addr = req_addr; nr.wdata = req_wdata;
`ifdef JTAG_AHB_AUTOINC_EN
    nr.incr  = req_incr;
`else
    nr.incr  = 1'b0;
`endif
    e_rv = 1'b0;
    if (m_in_addr) begin
      if (HREADY) begin
        e_htrans = 2'b00;
        if (m_cur.write) e_hwdata = m_cur.wdata;
        m_next_addr = e_haddr + 32'd4;
        m_in_addr = 0; m_in_data = 1;
      end
    end else if (m_in_data) begin
      if (HREADY) begin
        e_rv = 1'b1;
        if (m_err_seen || HRESP) e_err = 1'b1;
        else begin
          e_err = 1'b0;
          if (!m_cur.write) e_rdata = HRDATA;
        end
        m_in_data = 0; m_err_seen = 0;
      end else if (HRESP) begin
        m_err_seen = 1;
      end
    end else if (m_q.size() > 0) begin
      m_cur    = m_q.pop_front();
      e_haddr  = m_cur.incr ? m_next_addr : (m_cur.addr & 32'hFFFF_FFFC);
      e_htrans = 2'b10;
      e_hwrite = m_cur.write;
      m_in_addr = 1;
    end
    if (do_push) m_q.push_back(nr);
  endtask

  initial forever begin
    @(posedge HCLK or negedge HRESETn);
    if (!HRESETn) model_clear();
    else          model_step();
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  initial forever begin
    @(negedge HCLK);
    chk("htrans", HTRANS, e_htrans);
    chk("haddr", HADDR, e_haddr);
    chk("hwrite", HWRITE, e_hwrite);
    chk("hwdata", HWDATA, e_hwdata);
    chk("hsize", HSIZE, 3'b010);
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_rdata", resp_rdata, e_rdata);
    chk("resp_err", resp_err, e_err);
    chk("busy", busy, (m_q.size() != 0) || m_in_addr || m_in_data);
    chk("req_ready", req_ready, m_q.size() != DEPTH);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge HCLK);
    #1;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic inc);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
`ifdef JTAG_AHB_AUTOINC_EN
    req_incr = inc;
`else
    if (inc) $display("note: incr ignored in this build");
`endif
  endtask

  task automatic wait_resp(input int bound, input string name);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (resp_valid) seen = 1;
    end
    chk(name, seen, 1'b1);
  endtask

  initial begin
    int n;
    logic [AW-1:0] got;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_hsize", HSIZE, 3'b010);
    chk("rst_haddr", HADDR, 32'h0);
    HRESETn = 1'b1;
    tick();

    // Zero-wait write
    HREADY = 1'b1; HRESP = 1'b0;
    set_req(1'b1, 1'b1, 32'h2000_0013, 32'hDEAD_BEEF, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("t1_nonseq", HTRANS, 2'b10);
    chk("t1_haddr", HADDR, 32'h2000_0010);
    chk("t1_hwrite", HWRITE, 1'b1);
    tick();
    chk("t1_idle_after_accept", HTRANS, 2'b00);
    chk("t1_hwdata", HWDATA, 32'hDEAD_BEEF);
    tick();
    chk("t1_resp_valid_lat3", resp_valid, 1'b1);
    chk("t1_resp_err", resp_err, 1'b0);
    tick();
    chk("t1_resp_pulse_end", resp_valid, 1'b0);

    // Read with two data-phase wait states
    set_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("t2_haddr", HADDR, 32'h0000_0100);
    tick();
    HREADY = 1'b0;
    tick();
    chk("t2_wait_htrans", HTRANS, 2'b00);
    tick();
    chk("t2_wait_noresp", resp_valid, 1'b0);
    HREADY = 1'b1; HRDATA = 32'h1234_5678;
    tick();
    chk("t2_resp_valid_lat5", resp_valid, 1'b1);
    chk("t2_rdata", resp_rdata, 32'h1234_5678);

    // Read with ERROR response, then a queued write
    HRDATA = 32'hBAD0_BAD0;
    set_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0);
    tick();
    set_req(1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    HREADY = 1'b0; HRESP = 1'b1;
    tick();
    HREADY = 1'b1; HRESP = 1'b1;
    tick();
    chk("t3_err_resp", resp_valid, 1'b1);
    chk("t3_err_flag", resp_err, 1'b1);
    chk("t3_rdata_held", resp_rdata, 32'h1234_5678);
    HRESP = 1'b0;
    wait_resp(10, "t3_write_resp_timeout");
    chk("t3_write_ok", resp_err, 1'b0);
    tick();

    // FIFO fill while the slave stalls the address phase
    HREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, i[0], 32'h4000_0000 + 32'(i * 16), 32'hA000_0000 + 32'(i), 1'b0);
      tick();
    end
    chk("t4_req_ready_full", req_ready, 1'b0);
    set_req(1'b1, 1'b1, 32'h4000_1000, 32'h0, 1'b0);
    tick();
    chk("t4_still_full", req_ready, 1'b0);
    req_valid = 1'b0; HREADY = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_valid) n++;
    end
    chk("t4_resp_count", n, 5);

    // Reset during the data phase with two requests queued
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b1, 32'h5000_0000 + 32'(i * 4), 32'h0, 1'b0);
      tick();
    end
    req_valid = 1'b0; HREADY = 1'b0;
    tick();
    HRESETn = 1'b0;
    #1;
    chk("t5_htrans", HTRANS, 2'b00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_req_ready", req_ready, 1'b1);
    tick(); tick();
    HRESETn = 1'b1; HREADY = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_valid) n++;
    end
    chk("t5_no_resp", n, 0);
    chk("t5_idle", busy, 1'b0);

`ifdef JTAG_AHB_AUTOINC_EN
    // Auto-increment wraps past the top of the address space
    set_req(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1, 1'b0);
    tick();
    set_req(1'b1, 1'b1, 32'h0000_1234, 32'h2, 1'b1);
    tick();
    req_valid = 1'b0;
    n = 0; got = 32'hFFFF_FFFF;
    for (int i = 0; i < 12; i++) begin
      if (HTRANS == 2'b10) begin
        n++;
        if (n == 2) got = HADDR;
      end
      tick();
    end
    chk("t6_nonseq_count", n, 2);
    chk("t6_wrap_haddr", got, 32'h0);
`else
    got = 32'h0;
`endif

    // Randomised traffic with a randomised slave
    for (int c = 0; c < 3000; c++) begin
      set_req($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1, $urandom, $urandom,
              $urandom_range(0, 1) == 1);
      HRDATA = $urandom;
      if (m_in_data && !m_err_seen) begin
        if ($urandom_range(0, 9) == 0) begin
          HREADY = 1'b0; HRESP = 1'b1;
        end else begin
          HREADY = $urandom_range(0, 3) != 0; HRESP = 1'b0;
        end
      end else if (m_err_seen) begin
        HRESP = 1'b1; HREADY = $urandom_range(0, 1) == 1;
      end else begin
        HRESP = 1'b0; HREADY = $urandom_range(0, 3) != 0;
      end
      tick();
    end
    req_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("final_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
